// File: rtl/rgb2grey_pkg.sv
// Shared types, coefficients and arithmetic helpers for the RGB888 -> greyscale stream block.
// Luma weights are BT.601 scaled by 256 (77 + 150 + 29 = 256).
package rgb2grey_pkg;

  localparam logic [7:0]  COEF_R = 8'd77;
  localparam logic [7:0]  COEF_G = 8'd150;
  localparam logic [7:0]  COEF_B = 8'd29;
  localparam logic [15:0] ROUND  = 16'd128;

  typedef struct packed {
    logic [7:0] b;
    logic [7:0] g;
    logic [7:0] r;
  } pixel_t;

  typedef struct packed {
    pixel_t pixel;
    logic   tuser;
    logic   mode;
  } stage_t;

  // First stage: weighted channel products travel alongside the raw beat.
  typedef struct packed {
    logic [15:0] pr;
    logic [15:0] pg;
    logic [15:0] pb;
    stage_t      st;
  } s1_t;

  typedef struct packed {
    pixel_t pixel;
    logic   tuser;
  } s2_t;

  function automatic logic [15:0] scale(input logic [7:0] coef, input logic [7:0] chan);
    return 16'(coef) * 16'(chan);
  endfunction

  // Full-scale white sums to 65408, so the 16-bit accumulator cannot overflow.
  function automatic logic [7:0] luma(input logic [15:0] pr, input logic [15:0] pg,
                                      input logic [15:0] pb);
    logic [15:0] sum;
    sum = pr + pg + pb + ROUND;
    return 8'(sum >> 8);
  endfunction

endpackage

// File: rtl/axis_pipe_reg.sv
// One valid/ready pipeline register: loads when empty or when its content leaves this cycle.
// Data is held while stalled so the downstream side sees a stable beat.
module axis_pipe_reg #(
  parameter int unsigned W = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         s_valid_i,
  output logic         s_ready_o,
  input  logic [W-1:0] s_data_i,
  output logic         m_valid_o,
  input  logic         m_ready_i,
  output logic [W-1:0] m_data_o
);

  logic         valid_q, valid_d;
  logic [W-1:0] data_q, data_d;

  assign s_ready_o = ~valid_q | m_ready_i;
  assign m_valid_o = valid_q;
  assign m_data_o  = data_q;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (s_ready_o) begin
      valid_d = s_valid_i;
      if (s_valid_i) begin
        data_d = s_data_i;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: rtl/axis_rgb2grey.sv
// AXI4-Stream RGB888 -> greyscale converter with per-frame bypass, two-stage pipeline.
// Mode is latched at start-of-frame and carried with each beat so in-flight pixels keep theirs.
module axis_rgb2grey
  import rgb2grey_pkg::*;
#(
  parameter int unsigned BITS_PER_PIXEL   = 24,
  parameter int unsigned BITS_PER_CHANNEL = 8
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      enable_i,
  input  logic                      in_axis_tvalid,
  output logic                      in_axis_tready,
  input  logic [BITS_PER_PIXEL-1:0] in_axis_tdata,
  input  logic                      in_axis_tuser,
  output logic                      out_axis_tvalid,
  input  logic                      out_axis_tready,
  output logic [BITS_PER_PIXEL-1:0] out_axis_tdata,
  output logic                      out_axis_tuser,
  output logic                      mode_o,
  output logic [15:0]               frame_cnt_o
);

  if (BITS_PER_PIXEL != 24 || BITS_PER_CHANNEL != 8) begin : g_bad_cfg
    $error("axis_rgb2grey supports only 24-bit RGB888 pixels");
  end

  logic        mode_q, mode_d;
  logic [15:0] frame_cnt_q, frame_cnt_d;

  pixel_t in_px;
  logic   beat_mode;
  logic   in_fire, out_fire;
  logic   s1_ready, s1_valid, s2_ready, s2_valid;
  s1_t    s1_d, s1_q;
  s2_t    s2_d, s2_q;
  logic [7:0] y;

  assign in_px          = in_axis_tdata;
  assign in_axis_tready = s1_ready & ~rst_i;
  assign in_fire        = in_axis_tvalid & in_axis_tready;
  // A SOF beat already uses the newly requested mode, not the latched one.
  assign beat_mode      = in_axis_tuser ? enable_i : mode_q;

  always_comb begin
    s1_d.pr       = scale(COEF_R, in_px.r);
    s1_d.pg       = scale(COEF_G, in_px.g);
    s1_d.pb       = scale(COEF_B, in_px.b);
    s1_d.st.pixel = in_px;
    s1_d.st.tuser = in_axis_tuser;
    s1_d.st.mode  = beat_mode;
  end

  axis_pipe_reg #(
    .W($bits(s1_t))
  ) u_stage1 (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .s_valid_i (in_axis_tvalid),
    .s_ready_o (s1_ready),
    .s_data_i  (s1_d),
    .m_valid_o (s1_valid),
    .m_ready_i (s2_ready),
    .m_data_o  (s1_q)
  );

  always_comb begin
    y           = luma(s1_q.pr, s1_q.pg, s1_q.pb);
    s2_d.tuser  = s1_q.st.tuser;
    s2_d.pixel  = s1_q.st.pixel;
    if (s1_q.st.mode) begin
      s2_d.pixel = '{b: y, g: y, r: y};
    end
  end

  axis_pipe_reg #(
    .W($bits(s2_t))
  ) u_stage2 (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .s_valid_i (s1_valid),
    .s_ready_o (s2_ready),
    .s_data_i  (s2_d),
    .m_valid_o (s2_valid),
    .m_ready_i (out_axis_tready),
    .m_data_o  (s2_q)
  );

  assign out_axis_tvalid = s2_valid;
  assign out_axis_tdata  = s2_q.pixel;
  assign out_axis_tuser  = s2_q.tuser;
  assign out_fire        = out_axis_tvalid & out_axis_tready;

  always_comb begin
    mode_d      = mode_q;
    frame_cnt_d = frame_cnt_q;
    if (in_fire && in_axis_tuser) begin
      mode_d = enable_i;
    end
    if (out_fire && out_axis_tuser) begin
      frame_cnt_d = frame_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mode_q      <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      mode_q      <= mode_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign mode_o      = mode_q;
  assign frame_cnt_o = frame_cnt_q;

endmodule

// File: tb/tb_axis_rgb2grey.sv
// Scoreboard bench for axis_rgb2grey: stimulus pushes expected beats, a monitor pops on output handshakes.
module tb_axis_rgb2grey;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        in_tvalid;
  logic        in_tready;
  logic [23:0] in_tdata;
  logic        in_tuser;
  logic        out_tvalid;
  logic        out_tready;
  logic [23:0] out_tdata;
  logic        out_tuser;
  logic        mode;
  logic [15:0] frame_cnt;

  always #5 clk = ~clk;

  axis_rgb2grey #(
    .BITS_PER_PIXEL   (24),
    .BITS_PER_CHANNEL (8)
  ) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .enable_i        (enable),
    .in_axis_tvalid  (in_tvalid),
    .in_axis_tready  (in_tready),
    .in_axis_tdata   (in_tdata),
    .in_axis_tuser   (in_tuser),
    .out_axis_tvalid (out_tvalid),
    .out_axis_tready (out_tready),
    .out_axis_tdata  (out_tdata),
    .out_axis_tuser  (out_tuser),
    .mode_o          (mode),
    .frame_cnt_o     (frame_cnt)
  );

  int          total = 0;
  int          bad = 0;
  logic [24:0] exp_q[$];
  int          run_len = 0;
  int          max_run = 0;
  bit          held = 1'b0;
  logic [24:0] held_val;
  logic [24:0] cur;
  logic [24:0] exp_beat;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic logic [23:0] grey_of(input logic [23:0] p);
    int yy;
    yy = (77 * int'(p[7:0]) + 150 * int'(p[15:8]) + 29 * int'(p[23:16]) + 128) / 256;
    return {3{8'(yy)}};
  endfunction

  // Monitor: samples mid-cycle, after all negedge-driven inputs have settled.
  always begin
    @(negedge clk);
    #2;
    if (rst) begin
      held    = 1'b0;
      run_len = 0;
    end else begin
      cur = {out_tuser, out_tdata};
      if (held) begin
        total++;
        if ({out_tvalid, cur} !== {1'b1, held_val}) begin
          bad++;
          $display("FAIL stall_hold: got v=%b %h want v=1 %h", out_tvalid, cur, held_val);
        end
      end
      if (out_tvalid && out_tready) begin
        run_len++;
        if (run_len > max_run) max_run = run_len;
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_beat: got %h want none", cur);
        end else begin
          exp_beat = exp_q.pop_front();
          if (cur !== exp_beat) begin
            bad++;
            $display("FAIL out_beat: got %h want %h", cur, exp_beat);
          end
        end
      end else begin
        run_len = 0;
      end
      held     = out_tvalid && !out_tready;
      held_val = cur;
    end
  end

  task automatic send(input logic [23:0] d, input logic u, input logic en, input logic [23:0] exp_d);
    int waits = 0;
    @(negedge clk);
    in_tvalid = 1'b1;
    in_tdata  = d;
    in_tuser  = u;
    enable    = en;
    #1;
    while (!in_tready) begin
      waits++;
      if (waits > 200) begin
        total++;
        bad++;
        $display("FAIL send_timeout: in_tready=%b want 1", in_tready);
        in_tvalid = 1'b0;
        return;
      end
      @(negedge clk);
      #1;
    end
    exp_q.push_back({u, exp_d});
    @(posedge clk);
  endtask

  task automatic drain();
    int n = 0;
    @(negedge clk);
    in_tvalid = 1'b0;
    in_tuser  = 1'b0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("drain_empty", exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time exceeded");
    $fatal(1, "watchdog");
  end

  realtime t0, t1;

  initial begin
    rst        = 1'b1;
    enable     = 1'b0;
    in_tvalid  = 1'b0;
    in_tdata   = '0;
    in_tuser   = 1'b0;
    out_tready = 1'b1;

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    check("rst_out_valid", out_tvalid, 0);
    check("rst_out_data", out_tdata, 0);
    check("rst_mode", mode, 0);
    check("rst_frame_cnt", frame_cnt, 0);
    check("rst_in_ready", in_tready, 0);
    @(negedge clk);
    rst = 1'b0;

    // Colour conversion
    send(24'h000000, 1'b1, 1'b1, 24'h000000);
    send(24'h0000FF, 1'b0, 1'b1, 24'h4D4D4D);
    send(24'h00FF00, 1'b0, 1'b1, 24'h959595);
    send(24'hFF0000, 1'b0, 1'b1, 24'h1D1D1D);
    send(24'hFFFFFF, 1'b0, 1'b1, 24'hFFFFFF);
    drain();
    check("colour_mode", mode, 1);
    check("colour_frames", frame_cnt, 1);

    // Latency: single beat into an empty pipeline
    send(24'h808080, 1'b0, 1'b1, 24'h808080);
    #1;
    check("lat_n1_valid", out_tvalid, 0);
    @(negedge clk);
    in_tvalid = 1'b0;
    @(posedge clk);
    #1;
    check("lat_n2_valid", out_tvalid, 1);
    drain();

    // 100 back-to-back beats at full rate
    max_run = 0;
    for (int i = 0; i < 100; i++) begin
      logic [23:0] d;
      d = {8'(i), 8'(255 - i), 8'(3 * i)};
      send(d, 1'b0, 1'b1, grey_of(d));
      if (i == 0) t0 = $realtime;
      if (i == 99) t1 = $realtime;
    end
    drain();
    check("burst_accept_span", int'((t1 - t0) / 10.0), 99);
    check("burst_out_run", max_run, 100);

    // Backpressure: downstream stalls while beats keep arriving
    @(negedge clk);
    in_tvalid  = 1'b0;
    out_tready = 1'b0;
    fork
      begin
        send(24'h102030, 1'b0, 1'b1, 24'h232323);
        send(24'h808080, 1'b0, 1'b1, 24'h808080);
        send(24'h000000, 1'b0, 1'b1, 24'h000000);
        send(24'h123456, 1'b0, 1'b1, 24'h3A3A3A);
      end
      begin
        repeat (3) @(negedge clk);
        #1;
        check("bp_in_ready_low", in_tready, 0);
        check("bp_buffered", exp_q.size(), 2);
        check("bp_out_valid", out_tvalid, 1);
        repeat (3) @(negedge clk);
        out_tready = 1'b1;
      end
    join
    drain();

    // Mid-frame enable change only takes effect at the next SOF
    send(24'h123456, 1'b1, 1'b0, 24'h123456);
    #1;
    check("mf_mode_off", mode, 0);
    send(24'h0000FF, 1'b0, 1'b0, 24'h0000FF);
    send(24'h00FF00, 1'b0, 1'b1, 24'h00FF00);
    #1;
    check("mf_mode_hold", mode, 0);
    send(24'h0000FF, 1'b1, 1'b1, 24'h4D4D4D);
    #1;
    check("mf_mode_sof", mode, 1);
    send(24'h00FF00, 1'b0, 1'b0, 24'h959595);
    drain();
    check("mf_frames", frame_cnt, 3);

    // Reset with two beats in flight
    @(negedge clk);
    out_tready = 1'b0;
    send(24'hABCDEF, 1'b1, 1'b1, 24'h000000);
    send(24'h0000FF, 1'b0, 1'b1, 24'h4D4D4D);
    @(negedge clk);
    in_tvalid = 1'b0;
    rst       = 1'b1;
    @(negedge clk);
    #1;
    check("rr_out_valid", out_tvalid, 0);
    check("rr_mode", mode, 0);
    check("rr_frame_cnt", frame_cnt, 0);
    check("rr_in_ready", in_tready, 0);
    exp_q.delete();
    @(negedge clk);
    rst        = 1'b0;
    out_tready = 1'b1;
    repeat (6) @(negedge clk);
    #1;
    check("rr_no_stale", out_tvalid, 0);

    // Frame counter wrap
    for (int i = 0; i < 65535; i++) begin
      send(24'h000000, 1'b1, 1'b0, 24'h000000);
    end
    drain();
    check("wrap_full", frame_cnt, 16'hFFFF);
    send(24'h000000, 1'b1, 1'b0, 24'h000000);
    drain();
    check("wrap_zero", frame_cnt, 16'h0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
